// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the parity arbiter and its XOR-reduction datapath.
package parity_arb_pkg;

    localparam int DATA_W = 32;

    // Frame sequencer states: wait for a request, stream the owner's frame,
    // then present the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

endpackage

// File: rtl/parity_xor32.sv
// Combinational XOR reduction of one 32-bit word as a balanced 5-level tree.
module parity_xor32
    import parity_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);

    logic [15:0] w_l16;
    logic [7:0]  w_l8;
    logic [3:0]  w_l4;
    logic [1:0]  w_l2;

    // Pairwise XOR at each level halves the width until two bits remain.
    always_comb begin
        w_l16 = '0;
        w_l8  = '0;
        w_l4  = '0;
        w_l2  = '0;
        for (int i = 0; i < 16; i++) w_l16[i] = i_data[2*i] ^ i_data[2*i+1];
        for (int i = 0; i < 8; i++)  w_l8[i]  = w_l16[2*i] ^ w_l16[2*i+1];
        for (int i = 0; i < 4; i++)  w_l4[i]  = w_l8[2*i] ^ w_l8[2*i+1];
        for (int i = 0; i < 2; i++)  w_l2[i]  = w_l4[2*i] ^ w_l4[2*i+1];
    end

    assign o_parity = w_l2[0] ^ w_l2[1];

endmodule

// File: rtl/parity_arb.sv
// Round-robin arbiter sharing one parity reducer between two frame streams.
// Handshake: a word (or result) transfers on a rising edge where valid and
// ready are both high; producers hold data/last stable while valid && !ready.
// The grant is locked to one requester from its first word to its last word.
module parity_arb
    import parity_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic              res_parity,
    output logic [CNT_W-1:0]  res_words,
    output state_t            dbg_state
);

    state_t            r_state;
    req_id_t           r_rr;
    req_id_t           r_owner;
    logic              r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_res_valid;
    req_id_t           r_res_id;
    logic              r_res_parity;
    logic [CNT_W-1:0]  r_res_words;

    logic              w_valid;
    logic              w_last;
    logic [DATA_W-1:0] w_data;
    logic              w_word_par;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_next;
    req_id_t           w_grant;

    // Owner's stream feeds the single reducer instance.
    assign w_valid  = r_owner ? req1_valid : req0_valid;
    assign w_last   = r_owner ? req1_last  : req0_last;
    assign w_data   = r_owner ? req1_data  : req0_data;
    assign w_accept = (r_state == BUSY) && w_valid;

    // Word counter sticks at all-ones rather than wrapping.
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    parity_xor32 u_xor (
        .i_data   (w_data),
        .o_parity (w_word_par)
    );

    // Single valid requester wins outright; on a tie the rr pointer decides.
    always_comb begin
        w_grant = r_rr;
        if (req0_valid && !req1_valid)
            w_grant = 1'b0;
        else if (!req0_valid && req1_valid)
            w_grant = 1'b1;
    end

    // Frame sequencer: grant, accumulate, publish result, wait for consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr         <= 1'b0;
            r_owner      <= 1'b0;
            r_acc        <= 1'b0;
            r_cnt        <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= 1'b0;
            r_res_parity <= 1'b0;
            r_res_words  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_owner <= w_grant;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept) begin
                        r_acc <= r_acc ^ w_word_par;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            r_res_parity <= r_acc ^ w_word_par;
                            r_res_words  <= w_cnt_next;
                            r_res_id     <= r_owner;
                            r_res_valid  <= 1'b1;
                            r_rr         <= ~r_owner;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_acc       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = (r_state == BUSY) && (r_owner == 1'b0);
    assign req1_ready = (r_state == BUSY) && (r_owner == 1'b1);
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_parity = r_res_parity;
    assign res_words  = r_res_words;
    assign dbg_state  = r_state;

endmodule
